// File: rtl/avmm_pio_in_edge.sv
// Avalon-MM input PIO with a configurable-width input, a reset-0 synchronizer,
// per-bit edge capture, an interrupt mask and a level IRQ.
//
// Optional feature macro: PIO_BIT_CLEAR_EN
//   defined   : a write to EDGECAP clears only the bits set in writedata
//   undefined : any write to EDGECAP clears every capture bit
//
// Register map (bits at and above DATA_WIDTH read as 0):
//   0 DATA    synchronized input value, read-only
//   1 -       reserved, reads 0
//   2 IRQMASK read/write
//   3 EDGECAP read, write-to-clear

module avmm_pio_in_edge #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0   // 0 rising, 1 falling, 2 any
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  // Elaboration-time parameter range checks
  if (DATA_WIDTH < 1 || DATA_WIDTH > 32) begin : g_bad_width
    $error("avmm_pio_in_edge: DATA_WIDTH must be 1..32");
  end
  if (SYNC_STAGES > 3) begin : g_bad_sync
    $error("avmm_pio_in_edge: SYNC_STAGES must be 0..3");
  end
  if (EDGE_TYPE > 2) begin : g_bad_edge
    $error("avmm_pio_in_edge: EDGE_TYPE must be 0..2");
  end

  localparam logic [1:0] AddrData    = 2'd0;
  localparam logic [1:0] AddrIrqMask = 2'd2;
  localparam logic [1:0] AddrEdgeCap = 2'd3;

  // Warm-up count at which the synchronizer and prev stage hold real data
  localparam logic [2:0] WarmMax = 3'(SYNC_STAGES + 1);

  logic [DATA_WIDTH-1:0] data_sync;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
  logic [DATA_WIDTH-1:0] edge_rise, edge_fall, edge_raw, edge_hit;
  logic [DATA_WIDTH-1:0] clr;
  logic [2:0]            warm_q, warm_d;
  logic                  warm_done;
  logic                  wr_en;
  logic [31:0]           readdata_d;

  // Upper writedata bits are unused for narrow ports
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  //--------------------------------------------------------------------------
  // Input synchronizer
  //--------------------------------------------------------------------------
  if (SYNC_STAGES == 0) begin : g_no_sync
    assign data_sync = in_port;
  end else begin : g_sync
    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];

    // Shift in_port through the flop chain; last stage is the synchronized value
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < int'(SYNC_STAGES); i++) begin
          sync_q[i] <= '0;
        end
      end else begin
        sync_q[0] <= in_port;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign data_sync = sync_q[SYNC_STAGES-1];
  end

  // One-cycle delayed copy of the synchronized value for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= data_sync;
    end
  end

  //--------------------------------------------------------------------------
  // Warm-up counter: blocks the reset-release ramp from looking like an edge
  //--------------------------------------------------------------------------
  assign warm_done = (warm_q == WarmMax);

  // Count up after reset and hold once the pipeline has filled
  always_comb begin
    warm_d = warm_q;
    if (!warm_done) begin
      warm_d = warm_q + 3'd1;
    end
  end

  // Warm-up counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_q <= '0;
    end else begin
      warm_q <= warm_d;
    end
  end

  //--------------------------------------------------------------------------
  // Edge detect and selection
  //--------------------------------------------------------------------------
  // Per-bit edge detection, gated until warm-up completes
  always_comb begin
    edge_rise = data_sync & ~prev_q;
    edge_fall = ~data_sync & prev_q;
    if (EDGE_TYPE == 0) begin
      edge_raw = edge_rise;
    end else if (EDGE_TYPE == 1) begin
      edge_raw = edge_fall;
    end else begin
      edge_raw = edge_rise | edge_fall;
    end
    edge_hit = warm_done ? edge_raw : '0;
  end

  //--------------------------------------------------------------------------
  // Register writes
  //--------------------------------------------------------------------------
  assign wr_en = chipselect & ~write_n;

  // Mask load and capture-clear decode; set wins over clear on the same bit
  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (wr_en && (address == AddrIrqMask)) begin
      mask_d = writedata[DATA_WIDTH-1:0];
    end
    if (wr_en && (address == AddrEdgeCap)) begin
`ifdef PIO_BIT_CLEAR_EN
      clr = writedata[DATA_WIDTH-1:0];
`else
      clr = '1;
`endif
    end
    edgecap_d = (edgecap_q & ~clr) | edge_hit;
  end

  // Interrupt mask and edge capture registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q    <= '0;
      edgecap_q <= '0;
    end else begin
      mask_q    <= mask_d;
      edgecap_q <= edgecap_d;
    end
  end

  //--------------------------------------------------------------------------
  // Read path: registered every cycle from the current address
  //--------------------------------------------------------------------------
  // Read mux with zero-extension above DATA_WIDTH
  always_comb begin
    readdata_d = '0;
    case (address)
      AddrData:    readdata_d[DATA_WIDTH-1:0] = data_sync;
      AddrIrqMask: readdata_d[DATA_WIDTH-1:0] = mask_q;
      AddrEdgeCap: readdata_d[DATA_WIDTH-1:0] = edgecap_q;
      default:     readdata_d = '0;
    endcase
  end

  // Read data register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= readdata_d;
    end
  end

  // Level interrupt straight from the registers
  assign irq = |(edgecap_q & mask_q);

endmodule
